trap_ctrl: RTL and testbench

//   Trap sequencer between the pipeline and the CSR file. Arbitrates exceptions, mret and

---
 rtl/trap_ctrl_if.sv | 34 +++
 rtl/trap_ctrl.sv | 138 +++++++++++++
 tb/tb_trap_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-side signal bundle of the trap sequencer.
// slave modport is the sequencer's view; master is the pipeline/CSR/bench side.
interface trap_ctrl_if;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        mret_req;
  logic [31:0] int_pc;
  logic        ctrl_mie;
  logic [2:0]  ctrl_mxie;
  logic [2:0]  ctrl_mxip;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        pipe_empty;
  logic        stall_req;
  logic        ctrl_trap;
  logic        ctrl_mret;
  logic [31:0] trap_pc;
  logic [4:0]  trap_info;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  exc_valid, exc_cause, exc_pc, mret_req, int_pc, ctrl_mie, ctrl_mxie,
           ctrl_mxip, csr_mtvec, csr_mepc, pipe_empty,
    output stall_req, ctrl_trap, ctrl_mret, trap_pc, trap_info, redirect_valid, redirect_pc
  );

  modport master (
    output exc_valid, exc_cause, exc_pc, mret_req, int_pc, ctrl_mie, ctrl_mxie,
           ctrl_mxip, csr_mtvec, csr_mepc, pipe_empty,
    input  stall_req, ctrl_trap, ctrl_mret, trap_pc, trap_info, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates mret/exception/interrupt, drains the pipe, strobes the CSR
// file for one cycle, then redirects fetch to the handler or to mepc.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1
) (
  input logic        ctrl_clk,
  input logic        ctrl_reset,
  trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {K_NONE, K_EXC, K_INT, K_MRET} kind_t;

  state_t      state;
  kind_t       kind_q;
  logic [3:0]  cause_q;
  logic [31:0] pc_q;

  logic        trap_r;
  logic        mret_r;
  logic [31:0] trap_pc_r;
  logic [4:0]  trap_info_r;
  logic        redir_r;

  logic [2:0]  pend;
  logic        int_req;
  logic [3:0]  int_code;

  logic        cap_en;
  kind_t       cap_kind;
  logic [3:0]  cap_cause;
  logic [31:0] cap_pc;

  logic [31:0] base;

  assign pend     = bus.ctrl_mxie & bus.ctrl_mxip;
  assign int_req  = bus.ctrl_mie & (|pend);
  // bit0 external, bit1 software, bit2 timer
  assign int_code = pend[0] ? 4'd11 : (pend[1] ? 4'd3 : 4'd7);

  // Next latched request: fresh capture in IDLE, or an older exception preempting an interrupt.
  always_comb begin
    cap_en    = 1'b0;
    cap_kind  = kind_q;
    cap_cause = cause_q;
    cap_pc    = pc_q;
    if (state == IDLE) begin
      if (bus.mret_req) begin
        cap_en    = 1'b1;
        cap_kind  = K_MRET;
        cap_cause = 4'd0;
        cap_pc    = 32'd0;
      end else if (bus.exc_valid) begin
        cap_en    = 1'b1;
        cap_kind  = K_EXC;
        cap_cause = bus.exc_cause;
        cap_pc    = bus.exc_pc;
      end else if (int_req) begin
        cap_en    = 1'b1;
        cap_kind  = K_INT;
        cap_cause = int_code;
        cap_pc    = bus.int_pc;
      end
    end else if (state == DRAIN && kind_q == K_INT && bus.exc_valid) begin
      cap_en    = 1'b1;
      cap_kind  = K_EXC;
      cap_cause = bus.exc_cause;
      cap_pc    = bus.exc_pc;
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_reset) begin
      state       <= IDLE;
      kind_q      <= K_NONE;
      cause_q     <= 4'd0;
      pc_q        <= 32'd0;
      trap_r      <= 1'b0;
      mret_r      <= 1'b0;
      trap_pc_r   <= 32'd0;
      trap_info_r <= 5'd0;
      redir_r     <= 1'b0;
    end else begin
      trap_r      <= 1'b0;
      mret_r      <= 1'b0;
      trap_pc_r   <= 32'd0;
      trap_info_r <= 5'd0;
      redir_r     <= 1'b0;
      if (cap_en) begin
        kind_q  <= cap_kind;
        cause_q <= cap_cause;
        pc_q    <= cap_pc;
      end
      unique case (state)
        IDLE: if (cap_en) state <= DRAIN;
        DRAIN: begin
          if (bus.pipe_empty) begin
            // cap_* already folds in a same-cycle preemption
            state       <= COMMIT;
            trap_r      <= 1'b1;
            mret_r      <= (cap_kind == K_MRET);
            trap_pc_r   <= cap_pc;
            trap_info_r <= (cap_kind == K_MRET) ? 5'd0 : {cap_kind == K_INT, cap_cause};
          end
        end
        COMMIT: begin
          state   <= REDIRECT;
          redir_r <= 1'b1;
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // CSRs are read during REDIRECT so the COMMIT-cycle write is already visible.
  assign base = {bus.csr_mtvec[31:2], 2'b00};

  always_comb begin
    bus.redirect_pc = 32'd0;
    if (state == REDIRECT) begin
      if (kind_q == K_MRET)
        bus.redirect_pc = bus.csr_mepc;
      else if (VECTORED_EN && bus.csr_mtvec[1:0] == 2'b01 && kind_q == K_INT)
        bus.redirect_pc = base + {26'd0, cause_q, 2'b00};
      else
        bus.redirect_pc = base;
    end
  end

  assign bus.stall_req      = (state != IDLE);
  assign bus.ctrl_trap      = trap_r;
  assign bus.ctrl_mret      = mret_r;
  assign bus.trap_pc        = trap_pc_r;
  assign bus.trap_info      = trap_info_r;
  assign bus.redirect_valid = redir_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, reset/mask sequences, randomized requests vs model.
module tb_trap_ctrl;

  logic ctrl_clk = 1'b0;
  logic ctrl_reset = 1'b1;
  trap_ctrl_if bus ();

  trap_ctrl #(.VECTORED_EN(1'b1)) dut (
    .ctrl_clk   (ctrl_clk),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  typedef struct {
    logic        mret;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] ipc;
    logic        mie;
    logic [2:0]  mxie;
    logic [2:0]  mxip;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    int          drain;
    int          pre_at;
    logic [3:0]  pre_cause;
    logic [31:0] pre_pc;
    logic        e_mret;
    logic [4:0]  e_info;
    logic [31:0] e_pc;
    logic [31:0] e_rpc;
  } vec_t;

  int ncmp = 0;
  int nerr = 0;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic mret, input logic exc, input logic [3:0] cause,
                              input logic [31:0] epc, input logic [31:0] ipc, input logic mie,
                              input logic [2:0] mxie, input logic [2:0] mxip,
                              input logic [31:0] mtvec, input logic [31:0] mepc,
                              input int drain, input int pre_at, input logic [3:0] pre_cause,
                              input logic [31:0] pre_pc, input logic e_mret,
                              input logic [4:0] e_info, input logic [31:0] e_pc,
                              input logic [31:0] e_rpc);
    vec_t v;
    v.mret = mret; v.exc = exc; v.cause = cause; v.epc = epc; v.ipc = ipc;
    v.mie = mie; v.mxie = mxie; v.mxip = mxip; v.mtvec = mtvec; v.mepc = mepc;
    v.drain = drain; v.pre_at = pre_at; v.pre_cause = pre_cause; v.pre_pc = pre_pc;
    v.e_mret = e_mret; v.e_info = e_info; v.e_pc = e_pc; v.e_rpc = e_rpc;
    return v;
  endfunction

  // Reference: rules applied directly to one request, no cycle modelling.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int prio_bit[3] = '{0, 1, 2};
    int prio_code[3] = '{11, 3, 7};
    longint base = longint'(v.mtvec) - longint'(v.mtvec % 4);
    int code = -1;
    if (v.mret) begin
      r.e_mret = 1'b1; r.e_info = 5'd0; r.e_pc = 32'd0; r.e_rpc = v.mepc;
    end else if (v.exc) begin
      r.e_mret = 1'b0; r.e_info = {1'b0, v.cause}; r.e_pc = v.epc; r.e_rpc = 32'(base);
    end else begin
      for (int i = 2; i >= 0; i--)
        if (v.mxie[prio_bit[i]] && v.mxip[prio_bit[i]]) code = prio_code[i];
      r.e_mret = 1'b0;
      r.e_info = 5'(16 + code);
      r.e_pc   = v.ipc;
      r.e_rpc  = (v.mtvec % 4 == 1) ? 32'((base + 4 * code) % 64'h1_0000_0000) : 32'(base);
    end
    return r;
  endfunction

  task automatic clear_inputs();
    bus.exc_valid = 1'b0; bus.exc_cause = 4'd0; bus.exc_pc = 32'd0; bus.mret_req = 1'b0;
    bus.int_pc = 32'd0; bus.ctrl_mie = 1'b0; bus.ctrl_mxie = 3'd0; bus.ctrl_mxip = 3'd0;
    bus.csr_mtvec = 32'd0; bus.csr_mepc = 32'd0; bus.pipe_empty = 1'b1;
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge ctrl_clk);
    ctrl_reset = 1'b0;
  endtask

  // Called on a negedge; request is presented in the current cycle (T).
  task automatic run(input string nm, input vec_t v);
    int c = 0;
    bit got = 0;
    bus.mret_req = v.mret; bus.exc_valid = v.exc; bus.exc_cause = v.cause; bus.exc_pc = v.epc;
    bus.int_pc = v.ipc; bus.ctrl_mie = v.mie; bus.ctrl_mxie = v.mxie; bus.ctrl_mxip = v.mxip;
    bus.csr_mtvec = v.mtvec; bus.csr_mepc = v.mepc; bus.pipe_empty = 1'b0;
    while (!got && c < 40) begin
      @(negedge ctrl_clk);
      c++;
      bus.mret_req = 1'b0; bus.exc_valid = 1'b0;
      if (v.pre_at != 0 && c == v.pre_at) begin
        bus.exc_valid = 1'b1; bus.exc_cause = v.pre_cause; bus.exc_pc = v.pre_pc;
      end
      if (bus.ctrl_trap) got = 1;
      else begin
        if (c == 1) chk({nm, ".stall_drain"}, 32'(bus.stall_req), 32'd1);
        bus.pipe_empty = (c > v.drain);
      end
    end
    chk({nm, ".commit_cycle"}, 32'(c), 32'(v.drain + 2));
    if (!got) begin
      do_reset();
      return;
    end
    chk({nm, ".trap_info"}, 32'(bus.trap_info), 32'(v.e_info));
    chk({nm, ".trap_pc"}, bus.trap_pc, v.e_pc);
    chk({nm, ".ctrl_mret"}, 32'(bus.ctrl_mret), 32'(v.e_mret));
    chk({nm, ".redir_early"}, 32'(bus.redirect_valid), 32'd0);
    @(negedge ctrl_clk);
    chk({nm, ".trap_one_cycle"}, 32'(bus.ctrl_trap), 32'd0);
    chk({nm, ".redirect_valid"}, 32'(bus.redirect_valid), 32'd1);
    chk({nm, ".redirect_pc"}, bus.redirect_pc, v.e_rpc);
    chk({nm, ".trap_pc_idle"}, bus.trap_pc, 32'd0);
    clear_inputs();
    @(negedge ctrl_clk);
    chk({nm, ".redir_done"}, 32'(bus.redirect_valid), 32'd0);
    chk({nm, ".redir_pc_zero"}, bus.redirect_pc, 32'd0);
    chk({nm, ".stall_idle"}, 32'(bus.stall_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          mret exc cause epc      ipc      mie mxie    mxip    mtvec         mepc    dr pre pc   ppc    em info   e_pc     e_rpc
    tbl[0]  = mk(0, 1, 4'd2,  32'h100, 32'h0,   0, 3'b000, 3'b000, 32'h8000,     32'h0,   0, 0, 4'd0, 32'h0,  0, 5'h02, 32'h100, 32'h8000);
    tbl[1]  = mk(0, 0, 4'd0,  32'h0,   32'h500, 1, 3'b111, 3'b111, 32'h8001,     32'h0,   0, 0, 4'd0, 32'h0,  0, 5'h1B, 32'h500, 32'h802C);
    tbl[2]  = mk(1, 1, 4'd2,  32'h100, 32'h0,   0, 3'b000, 3'b000, 32'h8000,     32'h240, 0, 0, 4'd0, 32'h0,  1, 5'h00, 32'h0,   32'h240);
    tbl[3]  = mk(0, 0, 4'd0,  32'h0,   32'h300, 1, 3'b100, 3'b100, 32'h8001,     32'h0,   5, 2, 4'd5, 32'h44, 0, 5'h05, 32'h44,  32'h8000);
    tbl[4]  = mk(0, 0, 4'd0,  32'h0,   32'h600, 1, 3'b111, 3'b010, 32'h8001,     32'h0,   2, 0, 4'd0, 32'h0,  0, 5'h13, 32'h600, 32'h800C);
    tbl[5]  = mk(0, 0, 4'd0,  32'h0,   32'h10,  1, 3'b001, 3'b001, 32'hFFFFFFF1, 32'h0,   0, 0, 4'd0, 32'h0,  0, 5'h1B, 32'h10,  32'h1C);
    tbl[6]  = mk(0, 1, 4'd11, 32'h20,  32'h0,   0, 3'b000, 3'b000, 32'h9001,     32'h0,   1, 0, 4'd0, 32'h0,  0, 5'h0B, 32'h20,  32'h9000);
    tbl[7]  = mk(0, 1, 4'd3,  32'h30,  32'h90,  1, 3'b111, 3'b111, 32'h4000,     32'h0,   0, 0, 4'd0, 32'h0,  0, 5'h03, 32'h30,  32'h4000);
    tbl[8]  = mk(0, 0, 4'd0,  32'h0,   32'h70,  1, 3'b100, 3'b100, 32'h8003,     32'h0,   0, 0, 4'd0, 32'h0,  0, 5'h17, 32'h70,  32'h8000);
    tbl[9]  = mk(0, 0, 4'd0,  32'h0,   32'h80,  1, 3'b110, 3'b110, 32'h1001,     32'h0,   0, 0, 4'd0, 32'h0,  0, 5'h13, 32'h80,  32'h100C);
    tbl[10] = mk(0, 1, 4'd2,  32'hA0,  32'h0,   0, 3'b000, 3'b000, 32'h2000,     32'h0,   3, 2, 4'd9, 32'hBB, 0, 5'h02, 32'hA0,  32'h2000);

    do_reset();
    chk("reset.stall_req", 32'(bus.stall_req), 32'd0);
    chk("reset.ctrl_trap", 32'(bus.ctrl_trap), 32'd0);
    chk("reset.ctrl_mret", 32'(bus.ctrl_mret), 32'd0);
    chk("reset.trap_pc", bus.trap_pc, 32'd0);
    chk("reset.trap_info", 32'(bus.trap_info), 32'd0);
    chk("reset.redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("reset.redirect_pc", bus.redirect_pc, 32'd0);

    // Back-to-back: each run presents its request in the first IDLE cycle after the previous one.
    for (int i = 0; i < 11; i++) run($sformatf("vec%0d", i), tbl[i]);

    // Reset mid-DRAIN aborts silently and wins over a same-cycle request.
    @(negedge ctrl_clk);
    bus.exc_valid = 1'b1; bus.exc_cause = 4'd4; bus.exc_pc = 32'h55; bus.pipe_empty = 1'b0;
    @(negedge ctrl_clk);
    bus.exc_valid = 1'b0;
    chk("rst_drain.stall_before", 32'(bus.stall_req), 32'd1);
    ctrl_reset = 1'b1; bus.mret_req = 1'b1;
    @(negedge ctrl_clk);
    chk("rst_drain.stall_after", 32'(bus.stall_req), 32'd0);
    chk("rst_drain.ctrl_trap", 32'(bus.ctrl_trap), 32'd0);
    ctrl_reset = 1'b0; bus.mret_req = 1'b0; bus.pipe_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ctrl_clk);
      chk("rst_drain.no_trap", 32'(bus.ctrl_trap), 32'd0);
      chk("rst_drain.no_redirect", 32'(bus.redirect_valid), 32'd0);
      chk("rst_drain.stall_idle", 32'(bus.stall_req), 32'd0);
    end

    // mie=0 masks a pending timer interrupt; enabling it lets the interrupt through.
    bus.ctrl_mie = 1'b0; bus.ctrl_mxie = 3'b100; bus.ctrl_mxip = 3'b100; bus.csr_mtvec = 32'h8000;
    for (int i = 0; i < 3; i++) begin
      @(negedge ctrl_clk);
      chk("mie_mask.stall", 32'(bus.stall_req), 32'd0);
    end
    run("mie_unmask", mk(0, 0, 4'd0, 32'h0, 32'h700, 1, 3'b100, 3'b100, 32'h8000, 32'h0,
                         0, 0, 4'd0, 32'h0, 0, 5'h17, 32'h700, 32'h8000));

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      v = mk(0, 0, 4'd0, 32'h0, 32'h0, 0, 3'b000, 3'b000, 32'h0, 32'h0, 0, 0, 4'd0, 32'h0,
             0, 5'd0, 32'h0, 32'h0);
      v.mret  = ($urandom_range(0, 5) == 0);
      v.exc   = ($urandom_range(0, 2) == 0);
      v.cause = 4'($urandom_range(0, 15));
      v.epc   = $urandom & 32'hFFFF_FFFC;
      v.ipc   = $urandom & 32'hFFFF_FFFC;
      v.mie   = 1'($urandom_range(0, 1));
      v.mxie  = 3'($urandom_range(0, 7));
      v.mxip  = 3'($urandom_range(0, 7));
      v.mtvec = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      v.mepc  = $urandom;
      v.drain = $urandom_range(0, 4);
      if (!v.mret && !v.exc && !(v.mie && (v.mxie & v.mxip) != 3'd0)) v.exc = 1'b1;
      v = model(v);
      run($sformatf("rand%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
